// File: rtl/wash_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : wash_pkg
// Purpose  : Shared types and helpers for the wash-cycle timer: the phase
//            enumeration (its encoding is the externally visible phase code),
//            program-select codes, and a seconds-to-BCD converter used for
//            the per-phase duration constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wash_pkg;

  // Encoding is visible on the phase output; do not renumber.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] c_PROG_QUICK  = 2'd0;
  localparam logic [1:0] c_PROG_NORMAL = 2'd1;
  localparam logic [1:0] c_PROG_HEAVY  = 2'd2;
  localparam logic [1:0] c_PROG_RINSE  = 2'd3;

  // Converts 0..99 seconds to {tens, ones} BCD. Only ever evaluated on
  // elaboration-time constants, so the divide and modulo cost no logic.
  function automatic logic [7:0] to_bcd(input int unsigned secs);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(secs / 10);
    ones = 4'(secs % 10);
    return {tens, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_counter_2d.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bcd_down_counter_2d
// Purpose  : Two-digit BCD down counter with synchronous load. Load has
//            priority over decrement. A decrement at 00 is ignored so the
//            digits never leave the legal BCD range.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            i_load         - load i_load_val on the next edge
//            i_load_val[7:0]- {tens, ones} BCD value to load
//            i_dec_en       - decrement by one on the next edge
//            o_tens, o_ones - registered BCD digits
//            o_is_one       - digits currently read 01
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_counter_2d (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec_en,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_is_one
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (i_load) begin
      r_tens <= i_load_val[7:4];
      r_ones <= i_load_val[3:0];
    end else if (i_dec_en && ((r_tens != 4'd0) || (r_ones != 4'd0))) begin
      if (r_ones == 4'd0) begin
        r_ones <= 4'd9;
        r_tens <= r_tens - 4'd1;
      end else begin
        r_ones <= r_ones - 4'd1;
      end
    end
  end

  assign o_tens   = r_tens;
  assign o_ones   = r_ones;
  assign o_is_one = (r_tens == 4'd0) && (r_ones == 4'd1);

endmodule
`default_nettype wire

// File: rtl/wash_cycle_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : wash_cycle_timer
// Purpose  : Wash program sequencer (FILL -> WASH -> RINSE -> SPIN -> DONE,
//            rinse-only skips WASH) paced by a 1 s tick from a prescaler.
//            Shows remaining phase seconds as two BCD digits.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start               - level; rising edge starts a program
//            pause               - level; freezes prescaler and digits
//            abort               - level; forces IDLE, highest priority
//            door_closed         - door sensor
//            prog[1:0]           - 0 quick, 1 normal, 2 heavy, 3 rinse-only
//            bcd_tens, bcd_ones  - remaining seconds of current phase
//            phase[2:0]          - state code
//            valve_on, motor_on, door_lock, done - registered actuator decode
// Revision : 1.0 - initial release
// ============================================================================
module wash_cycle_timer
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int FILL_S   = 10,
  parameter int RINSE_S  = 30,
  parameter int SPIN_S   = 20,
  parameter int WASH_Q_S = 20,
  parameter int WASH_N_S = 40,
  parameter int WASH_H_S = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic       door_closed,
  input  logic [1:0] prog,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [2:0] phase,
  output logic       valve_on,
  output logic       motor_on,
  output logic       door_lock,
  output logic       done
);

  localparam int              c_PW         = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0] c_PRESC_MAX  = c_PW'(TICK_DIV - 1);
  localparam logic [7:0]      c_FILL_BCD   = to_bcd(FILL_S);
  localparam logic [7:0]      c_RINSE_BCD  = to_bcd(RINSE_S);
  localparam logic [7:0]      c_SPIN_BCD   = to_bcd(SPIN_S);
  localparam logic [7:0]      c_WASH_Q_BCD = to_bcd(WASH_Q_S);
  localparam logic [7:0]      c_WASH_N_BCD = to_bcd(WASH_N_S);
  localparam logic [7:0]      c_WASH_H_BCD = to_bcd(WASH_H_S);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_prog;
  logic            r_start_q;
  logic [c_PW-1:0] r_presc;
  logic            r_valve;
  logic            r_motor;
  logic            r_lock;
  logic            r_done;

  logic            w_run;
  logic            w_tick;
  logic            w_go;
  logic            w_load;
  logic [7:0]      w_load_val;
  logic            w_dec;
  logic            w_is_one;

  function automatic state_t next_phase(input state_t s, input logic [1:0] p);
    case (s)
      ST_FILL:  return (p == c_PROG_RINSE) ? ST_RINSE : ST_WASH;
      ST_WASH:  return ST_RINSE;
      ST_RINSE: return ST_SPIN;
      default:  return ST_DONE;
    endcase
  endfunction

  // Duration loaded on entry to a phase; DONE (and anything else) shows 00.
  function automatic logic [7:0] phase_bcd(input state_t s, input logic [1:0] p);
    case (s)
      ST_FILL:  return c_FILL_BCD;
      ST_WASH:  return (p == c_PROG_QUICK) ? c_WASH_Q_BCD :
                       (p == c_PROG_HEAVY) ? c_WASH_H_BCD : c_WASH_N_BCD;
      ST_RINSE: return c_RINSE_BCD;
      ST_SPIN:  return c_SPIN_BCD;
      default:  return 8'h00;
    endcase
  endfunction

  assign w_run  = ((r_state == ST_FILL) || (r_state == ST_WASH) ||
                   (r_state == ST_RINSE) || (r_state == ST_SPIN)) &&
                  !pause && door_closed;
  assign w_tick = w_run && (r_presc == c_PRESC_MAX);
  assign w_go   = (r_state == ST_IDLE) && start && !r_start_q &&
                  door_closed && !abort;

  // Next state and digit control. Abort overrides ticks and start edges.
  // On the final second (digits 01) a tick loads the next phase instead of
  // decrementing, so 00 never appears mid-program.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = 8'h00;
    w_dec       = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            w_state_nxt = ST_FILL;
            w_load      = 1'b1;
            w_load_val  = c_FILL_BCD;
          end
        end
        ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
          if (w_tick) begin
            if (w_is_one) begin
              w_state_nxt = next_phase(r_state, r_prog);
              w_load      = 1'b1;
              w_load_val  = phase_bcd(next_phase(r_state, r_prog), r_prog);
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!door_closed) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_load      = 1'b1;
        end
      endcase
    end
  end

  // Actuator outputs decode from the next state so they update on the same
  // edge as phase while still being driven from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_prog    <= 2'd0;
      r_start_q <= 1'b0;
      r_presc   <= '0;
      r_valve   <= 1'b0;
      r_motor   <= 1'b0;
      r_lock    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_start_q <= start;
      r_state   <= w_state_nxt;
      r_valve   <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_RINSE);
      r_motor   <= (w_state_nxt == ST_WASH) || (w_state_nxt == ST_RINSE) ||
                   (w_state_nxt == ST_SPIN);
      r_lock    <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_done    <= (w_state_nxt == ST_DONE);
      if (w_go) r_prog <= prog;
      if (abort || w_go || w_tick) begin
        r_presc <= '0;
      end else if (w_run) begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  bcd_down_counter_2d u_digits (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec_en   (w_dec),
    .o_tens     (bcd_tens),
    .o_ones     (bcd_ones),
    .o_is_one   (w_is_one)
  );

  assign phase     = r_state;
  assign valve_on  = r_valve;
  assign motor_on  = r_motor;
  assign door_lock = r_lock;
  assign done      = r_done;

endmodule
`default_nettype wire
